// File: rtl/mac_seq.sv
// Sequencer for one FP32 multiply-accumulate PE: accepts len operand pairs,
// pulses the PE enables with the pipeline latencies and captures the dot product.
//
// state | meaning
// IDLE  | waiting for start with a legal len
// CLEAR | one-cycle clear of multiplier and accumulator
// FEED  | accepting operand pairs until len have been taken
// DRAIN | waiting for the last product to land in the accumulator
// DONE  | holding the captured result until it is consumed
module mac_seq #(
  parameter int MULT_LAT = 1,
  parameter int ACC_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  len,
  input  logic        abort,
  output logic        busy,
  input  logic        op_valid,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  output logic [31:0] mac_a,
  output logic [31:0] mac_b,
  output logic        en_mult,
  output logic        clr_mult,
  output logic        en_accum,
  output logic        clr_accum,
  output logic        accum_start,
  input  logic [31:0] mac_result,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready
);

  localparam int AW = $clog2(ACC_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [4:0]            len_q, len_d, cnt_q, cnt_d;
  logic [31:0]           mac_a_q, mac_a_d, mac_b_q, mac_b_d, res_data_q, res_data_d;
  logic                  en_mult_q, en_mult_d, clr_q, clr_d, first_q, first_d;
  logic                  res_valid_q, res_valid_d;
  logic [MULT_LAT-1:0]   dly_q, dly_d;
  logic [AW-1:0]         acc_cnt_q, acc_cnt_d;
  logic                  abort_hit, accept, dly_out, pipe_empty;

  assign abort_hit  = abort && (state_q != S_IDLE);
  assign op_ready   = (state_q == S_FEED) && (cnt_q < len_q) && !abort;
  assign accept     = op_ready && op_valid;
  assign dly_out    = dly_q[MULT_LAT-1];
  assign pipe_empty = !en_mult_q && (dly_q == '0);

  // Enables are masked in the abort cycle itself so nothing new reaches the PE
  assign en_mult     = en_mult_q && !abort_hit;
  assign en_accum    = dly_out && !abort_hit;
  assign accum_start = dly_out && first_q && !abort_hit;
  assign clr_mult    = clr_q;
  assign clr_accum   = clr_q;
  assign busy        = (state_q != S_IDLE);
  assign mac_a       = mac_a_q;
  assign mac_b       = mac_b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    en_mult_d   = 1'b0;
    clr_d       = 1'b0;
    first_d     = first_q;
    dly_d[0]    = en_mult_q;
    for (int i = 1; i < MULT_LAT; i++) dly_d[i] = dly_q[i-1];
    acc_cnt_d   = acc_cnt_q;
    if (dly_out) begin
      acc_cnt_d = AW'(ACC_LAT);
      first_d   = 1'b0;
    end else if (acc_cnt_q != '0) begin
      acc_cnt_d = acc_cnt_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && (len != 5'd0)) begin
          len_d   = len;
          cnt_d   = 5'd0;
          first_d = 1'b1;
          clr_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (accept) begin
          mac_a_d   = op_a;
          mac_b_d   = op_b;
          en_mult_d = 1'b1;
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Terminal count of 1 means this edge is ACC_LAT cycles past the last accumulate
        if (pipe_empty && (acc_cnt_q == AW'(1))) begin
          res_data_d  = mac_result;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      state_d     = S_IDLE;
      en_mult_d   = 1'b0;
      dly_d       = '0;
      acc_cnt_d   = '0;
      first_d     = 1'b0;
      clr_d       = 1'b1;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= 5'd0;
      cnt_q       <= 5'd0;
      mac_a_q     <= 32'h0;
      mac_b_q     <= 32'h0;
      res_data_q  <= 32'h0;
      res_valid_q <= 1'b0;
      en_mult_q   <= 1'b0;
      clr_q       <= 1'b0;
      first_q     <= 1'b0;
      dly_q       <= '0;
      acc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      en_mult_q   <= en_mult_d;
      clr_q       <= clr_d;
      first_q     <= first_d;
      dly_q       <= dly_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

endmodule
